// File: rtl/uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// Exports the FSM state enum and the start/stop/idle line constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_IDLE      = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
// Ports: clk, rst, clr (sync clear), bit_tick (high on last count).
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and sends them as 8N1 UART frames.
// Ports: clk, rst, tx_en, fifo_empty, fifo_rd_data in;
//        fifo_rd_en, tx, busy, tx_done out.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_e       state;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_idx;
  logic              bit_tick;
  logic              baud_clr;

  // Counter only runs while the line is driving a frame bit.
  assign baud_clr = !(state == ST_START ||
                      state == ST_DATA  ||
                      state == ST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= UART_IDLE;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tx <= UART_IDLE;
          if (tx_en && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          fifo_rd_en <= 1'b0;
          state      <= ST_LOAD;
        end
        ST_LOAD: begin
          shift <= fifo_rd_data;
          tx    <= UART_START_BIT;
          state <= ST_START;
        end
        ST_START: begin
          if (bit_tick) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              tx    <= UART_STOP_BIT;
              state <= ST_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            tx_done <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
